// File: rtl/hjbridge_pkg.sv
// Shared types and constants for the byte-stream to register-bus bridge.
package hjbridge_pkg;

  typedef enum logic [2:0] {
    StCmd,
    StAddr,
    StWdata,
    StReq,
    StWait,
    StStat,
    StRdata
  } state_e;

  // Response status codes
  localparam logic [7:0] StatusOk      = 8'h00;
  localparam logic [7:0] StatusSlvErr  = 8'h01;
  localparam logic [7:0] StatusTimeout = 8'h02;
  localparam logic [7:0] StatusBadCmd  = 8'h03;

  // Command byte 0 layout
  localparam int unsigned CmdWrBit   = 7;
  localparam int unsigned CmdRsvdMsb = 6;
  localparam int unsigned CmdRsvdLsb = 4;
  localparam int unsigned CmdAddrMsb = 3;
  localparam int unsigned CmdAddrLsb = 0;

endpackage

// File: rtl/hjbridge_if.sv
// Byte streams plus register bus seen by the bridge; master = bridge side.
interface hjbridge_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        regreq;
  logic        regwr;
  logic [11:0] regaddr;
  logic [31:0] regwdata;
  logic        regack;
  logic        regerr;
  logic [31:0] regrdata;

  modport master (
    input  rx_data, rx_valid, tx_ready, regack, regerr, regrdata,
    output rx_ready, tx_data, tx_valid, regreq, regwr, regaddr, regwdata
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, regack, regerr, regrdata,
    input  rx_ready, tx_data, tx_valid, regreq, regwr, regaddr, regwdata
  );
endinterface

// File: rtl/hjbridge.sv
// Decodes command frames from a byte stream, issues one register transaction
// per frame and returns a status (plus read data) frame on the outgoing stream.
module hjbridge
  import hjbridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  hjbridge_if.master bus
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic            rstn_q;
  logic [1:0]      cnt_q, cnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [7:0]      status_q, status_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            wr_q, wr_d;
  logic [11:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            rx_fire, tx_fire;

  assign rx_fire = bus.rx_valid & bus.rx_ready;
  assign tx_fire = bus.tx_valid & bus.tx_ready;

  // Bus request fields come straight from the frame registers so they hold
  // through REQ/WAIT until the next frame overwrites them.
  assign bus.regwr    = wr_q;
  assign bus.regaddr  = addr_q;
  assign bus.regwdata = wdata_q;

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= StCmd;
      rstn_q   <= 1'b0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      status_q <= StatusOk;
      rdata_q  <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rstn_q   <= 1'b1;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Frame sequencing, stream handshakes and bus strobe
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    status_d     = status_q;
    rdata_d      = rdata_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    bus.rx_ready = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    bus.regreq   = 1'b0;

    unique case (state_q)
      StCmd: begin
        // Held off for one cycle after reset release
        bus.rx_ready = rstn_q;
        if (rx_fire) begin
          if (|bus.rx_data[CmdRsvdMsb:CmdRsvdLsb]) begin
            status_d = StatusBadCmd;
            state_d  = StStat;
          end else begin
            wr_d         = bus.rx_data[CmdWrBit];
            addr_d[11:8] = bus.rx_data[CmdAddrMsb:CmdAddrLsb];
            state_d      = StAddr;
          end
        end
      end
      StAddr: begin
        bus.rx_ready = 1'b1;
        if (rx_fire) begin
          addr_d[7:0] = bus.rx_data;
          cnt_d       = 2'd0;
          state_d     = wr_q ? StWdata : StReq;
        end
      end
      StWdata: begin
        bus.rx_ready = 1'b1;
        if (rx_fire) begin
          wdata_d = {wdata_q[23:0], bus.rx_data};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = StReq;
        end
      end
      StReq: begin
        bus.regreq = 1'b1;
        tmo_d      = '0;
        state_d    = StWait;
      end
      StWait: begin
        // An ack in the last wait cycle still beats the timeout
        if (bus.regack) begin
          rdata_d  = bus.regrdata;
          status_d = bus.regerr ? StatusSlvErr : StatusOk;
          state_d  = StStat;
        end else if (tmo_q == TmoLast) begin
          status_d = StatusTimeout;
          state_d  = StStat;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StStat: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = status_q;
        if (tx_fire) begin
          if (status_q == StatusOk && !wr_q) begin
            cnt_d   = 2'd0;
            state_d = StRdata;
          end else begin
            state_d = StCmd;
          end
        end
      end
      StRdata: begin
        bus.tx_valid = 1'b1;
        // MSB first: byte index 3-cnt, i.e. ~cnt for a 2-bit counter
        bus.tx_data  = rdata_q[{~cnt_q, 3'b000} +: 8];
        if (tx_fire) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = StCmd;
        end
      end
      default: state_d = StCmd;
    endcase
  end

endmodule
